// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the two SDRAM requesters, the arbiter and the bridge port.
// slave: arbiter view (requests/bridge responses in); master: environment view.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16
);
    logic              init_bus_enable;
    logic              init_rw;
    logic [ADDR_W-1:0] init_address;
    logic [1:0]        init_byte_enable;
    logic [DATA_W-1:0] init_write_data;
    logic              init_acknowledge;
    logic [DATA_W-1:0] init_read_data;

    logic              aud_req;
    logic [ADDR_W-1:0] aud_address;
    logic              aud_ack;
    logic [DATA_W-1:0] aud_read_data;

    logic [ADDR_W-1:0] ar_addr;
    logic [1:0]        ar_be;
    logic              ar_read;
    logic              ar_write;
    logic [DATA_W-1:0] ar_wrdata;
    logic              ar_ac;
    logic [DATA_W-1:0] ar_rddata;

    logic              busy;
    logic              timeout_err;

    modport slave (
        input  init_bus_enable, init_rw, init_address,
        input  init_byte_enable, init_write_data,
        output init_acknowledge, init_read_data,
        input  aud_req, aud_address,
        output aud_ack, aud_read_data,
        output ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
        input  ar_ac, ar_rddata,
        output busy, timeout_err
    );

    modport master (
        output init_bus_enable, init_rw, init_address,
        output init_byte_enable, init_write_data,
        input  init_acknowledge, init_read_data,
        output aud_req, aud_address,
        input  aud_ack, aud_read_data,
        input  ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
        output ar_ac, ar_rddata,
        input  busy, timeout_err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter/sequencer sharing one SDRAM bridge port between the CPU
// init bridge and the audio fetcher; one transaction at a time, hung-bridge timeout.
// Ports: clk, rst (async, active high), bus (sdram_arbiter_if.slave).
module sdram_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    sdram_arbiter_if.slave  bus
);
    localparam logic [DATA_W-1:0] DEAD = DATA_W'(16'hDEAD);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_AUD, DONE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       last_aud;
    logic       cpu_win;
    logic       aud_win;
    logic       finish;

    // On a tie the requester that did not win last time is served.
    assign cpu_win = bus.init_bus_enable & (~bus.aud_req | last_aud);
    assign aud_win = bus.aud_req & ~cpu_win;

    // Bridge ack beats a timeout landing in the same cycle.
    assign finish = bus.ar_ac | (cnt == TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            last_aud             <= 1'b1;
            bus.ar_addr          <= ADDR_ZERO;
            bus.ar_be            <= '0;
            bus.ar_read          <= 1'b0;
            bus.ar_write         <= 1'b0;
            bus.ar_wrdata        <= '0;
            bus.init_acknowledge <= 1'b0;
            bus.init_read_data   <= '0;
            bus.aud_ack          <= 1'b0;
            bus.aud_read_data    <= '0;
            bus.busy             <= 1'b0;
            bus.timeout_err      <= 1'b0;
        end else begin
            bus.init_acknowledge <= 1'b0;
            bus.aud_ack          <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        cpu_win: begin
                            state         <= GNT_CPU;
                            last_aud      <= 1'b0;
                            cnt           <= '0;
                            bus.busy      <= 1'b1;
                            bus.ar_addr   <= bus.init_address;
                            bus.ar_be     <= bus.init_byte_enable;
                            bus.ar_wrdata <= bus.init_write_data;
                            bus.ar_read   <= bus.init_rw;
                            bus.ar_write  <= ~bus.init_rw;
                        end
                        aud_win: begin
                            state         <= GNT_AUD;
                            last_aud      <= 1'b1;
                            cnt           <= '0;
                            bus.busy      <= 1'b1;
                            bus.ar_addr   <= bus.aud_address;
                            bus.ar_be     <= 2'b11;
                            bus.ar_wrdata <= '0;
                            bus.ar_read   <= 1'b1;
                            bus.ar_write  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                GNT_CPU, GNT_AUD: begin
                    if (finish) begin
                        state        <= DONE;
                        bus.ar_read  <= 1'b0;
                        bus.ar_write <= 1'b0;
                        if (!bus.ar_ac)
                            bus.timeout_err <= 1'b1;
                        if (state == GNT_CPU) begin
                            bus.init_acknowledge <= 1'b1;
                            bus.init_read_data   <= bus.ar_ac ? bus.ar_rddata : DEAD;
                        end else begin
                            bus.aud_ack       <= 1'b1;
                            bus.aud_read_data <= bus.ar_ac ? bus.ar_rddata : DEAD;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // One quiet cycle so the requester can drop its request.
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_sdram_arbiter;
    localparam int AW  = 26;
    localparam int DW  = 16;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model
    bit          g_act, g_done, g_aud, m_last_aud, m_err;
    int          g_cnt;
    logic [AW-1:0] e_addr;
    logic [1:0]  e_be;
    logic        e_rd, e_wr;
    logic [DW-1:0] e_wd, m_cpu_rd, m_aud_rd;
    bit          ac_sent;
    logic [DW-1:0] ac_data;
    bit          use_fix;
    logic [DW-1:0] fix_val;

    int ack_who[$];
    int ack_t[$];
    int n_cpu_ack, n_aud_ack, n_rd, n_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        g_act = 0; g_done = 0; g_aud = 0; g_cnt = 0;
        m_last_aud = 1; m_err = 0;
        e_addr = '0; e_be = '0; e_rd = 0; e_wr = 0; e_wd = '0;
        m_cpu_rd = '0; m_aud_rd = '0;
        ac_sent = 0;
    endtask

    task automatic clr_stats();
        ack_who.delete(); ack_t.delete();
        n_cpu_ack = 0; n_aud_ack = 0; n_rd = 0; n_wr = 0;
    endtask

    // Advance one cycle, predict what the arbiter must show, compare.
    task automatic step();
        logic [DW-1:0] d;
        bit ea_cpu, ea_aud;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ea_cpu = 0;
        ea_aud = 0;
        if (g_act) begin
            if (ac_sent || g_cnt == TMO) begin
                d = ac_sent ? ac_data : 16'hDEAD;
                if (!ac_sent) m_err = 1;
                if (g_aud) begin m_aud_rd = d; ea_aud = 1; end
                else begin m_cpu_rd = d; ea_cpu = 1; end
                g_act = 0; g_done = 1; e_rd = 0; e_wr = 0;
            end else begin
                g_cnt++;
            end
        end else if (g_done) begin
            g_done = 0;
        end else if (bus.init_bus_enable || bus.aud_req) begin
            if (bus.init_bus_enable && bus.aud_req) g_aud = !m_last_aud;
            else g_aud = bus.aud_req;
            m_last_aud = g_aud;
            g_act = 1;
            g_cnt = 0;
            if (g_aud) begin
                e_addr = bus.aud_address; e_be = 2'b11; e_wd = '0;
                e_rd = 1; e_wr = 0;
            end else begin
                e_addr = bus.init_address; e_be = bus.init_byte_enable;
                e_wd = bus.init_write_data; e_rd = bus.init_rw; e_wr = !bus.init_rw;
            end
        end
        if (bus.init_acknowledge) begin
            ack_who.push_back(0); ack_t.push_back(cyc); n_cpu_ack++;
        end
        if (bus.aud_ack) begin
            ack_who.push_back(1); ack_t.push_back(cyc); n_aud_ack++;
        end
        if (bus.ar_read) n_rd++;
        if (bus.ar_write) n_wr++;
        chk("ar_read", 32'(bus.ar_read), 32'(e_rd));
        chk("ar_write", 32'(bus.ar_write), 32'(e_wr));
        chk("ar_addr", 32'(bus.ar_addr), 32'(e_addr));
        chk("ar_be", 32'(bus.ar_be), 32'(e_be));
        chk("ar_wrdata", 32'(bus.ar_wrdata), 32'(e_wd));
        chk("init_ack", 32'(bus.init_acknowledge), 32'(ea_cpu));
        chk("aud_ack", 32'(bus.aud_ack), 32'(ea_aud));
        chk("init_rdata", 32'(bus.init_read_data), 32'(m_cpu_rd));
        chk("aud_rdata", 32'(bus.aud_read_data), 32'(m_aud_rd));
        chk("busy", 32'(bus.busy), 32'(g_act || g_done));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        bus.ar_ac = 0;
        ac_sent = 0;
    endtask

    // Bridge acks once the grant has lasted lat+1 cycles (lat<0: never).
    task automatic drive_bridge(input int lat, input bit stray);
        if (g_act) begin
            if (lat >= 0 && g_cnt >= lat) begin
                bus.ar_ac = 1;
                bus.ar_rddata = use_fix ? fix_val : 16'($urandom);
                ac_sent = 1;
                ac_data = bus.ar_rddata;
            end
        end else if (stray) begin
            bus.ar_ac = 1;
            bus.ar_rddata = 16'($urandom);
        end
    endtask

    task automatic run(input int n, input int lat, input bit hold, input bit stray);
        for (int i = 0; i < n; i++) begin
            step();
            if (!hold) begin
                if (bus.init_acknowledge) bus.init_bus_enable = 0;
                if (bus.aud_ack) bus.aud_req = 0;
            end
            drive_bridge(lat, stray);
        end
    endtask

    task automatic cpu_req(input bit rw, input logic [AW-1:0] a,
                           input logic [1:0] be, input logic [DW-1:0] wd);
        bus.init_bus_enable = 1; bus.init_rw = rw; bus.init_address = a;
        bus.init_byte_enable = be; bus.init_write_data = wd;
    endtask

    task automatic aud_rq(input logic [AW-1:0] a);
        bus.aud_req = 1; bus.aud_address = a;
    endtask

    int cgap, agap, rlat;

    initial begin
        bus.init_bus_enable = 0; bus.init_rw = 0; bus.init_address = '0;
        bus.init_byte_enable = '0; bus.init_write_data = '0;
        bus.aud_req = 0; bus.aud_address = '0;
        bus.ar_ac = 0; bus.ar_rddata = '0;
        use_fix = 0; fix_val = '0;
        model_reset();
        clr_stats();

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ar_read", 32'(bus.ar_read), 32'd0);
        chk("rst_terr", 32'(bus.timeout_err), 32'd0);
        rst = 0;

        // CPU write, bridge acks on the third grant cycle
        cpu_req(1'b0, 26'h0000123, 2'b01, 16'hA5A5);
        run(8, 2, 0, 0);
        chk("wr_cycles", 32'(n_wr), 32'd3);
        chk("wr_cpu_acks", 32'(n_cpu_ack), 32'd1);
        chk("wr_aud_acks", 32'(n_aud_ack), 32'd0);
        chk("wr_reads", 32'(n_rd), 32'd0);

        // audio read
        clr_stats();
        use_fix = 1; fix_val = 16'h7F01;
        aud_rq(26'h0100000);
        run(6, 0, 0, 0);
        use_fix = 0;
        chk("aud_rdata_fix", 32'(bus.aud_read_data), 32'h7F01);
        chk("aud_acks", 32'(n_aud_ack), 32'd1);
        chk("aud_reads", 32'(n_rd), 32'd1);

        // continuous contention, bridge acks after one cycle
        clr_stats();
        cpu_req(1'b1, 26'h0000040, 2'b11, 16'h0);
        aud_rq(26'h0200000);
        run(17, 1, 1, 0);
        bus.init_bus_enable = 0;
        bus.aud_req = 0;
        run(8, 1, 0, 0);
        chk("cont_n", 32'(ack_who.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < ack_who.size(); k++) begin
            chk("cont_who", 32'(ack_who[k]), 32'(k % 2));
            if (k > 0) chk("cont_gap", 32'(ack_t[k] - ack_t[k-1]), 32'd4);
        end

        // stray acks in IDLE, then through DONE of a real read
        clr_stats();
        run(5, -1, 0, 1);
        cpu_req(1'b1, 26'h0000777, 2'b10, 16'h0);
        run(6, 0, 0, 1);
        run(3, -1, 0, 1);
        chk("stray_cpu", 32'(n_cpu_ack), 32'd1);
        chk("stray_aud", 32'(n_aud_ack), 32'd0);

        // timeout on a CPU read
        clr_stats();
        cpu_req(1'b1, 26'h0001000, 2'b11, 16'h0);
        run(262, -1, 0, 0);
        chk("tmo_rd_cycles", 32'(n_rd), 32'(TMO + 1));
        chk("tmo_acks", 32'(n_cpu_ack), 32'd1);
        chk("tmo_rdata", 32'(bus.init_read_data), 32'hDEAD);
        chk("tmo_err", 32'(bus.timeout_err), 32'd1);

        // random traffic
        cgap = 0; agap = 0; rlat = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (bus.init_bus_enable) begin
                if (bus.init_acknowledge) begin
                    bus.init_bus_enable = 0; cgap = $urandom_range(0, 3);
                end
            end else if (cgap > 0) cgap--;
            else if ($urandom_range(0, 1) == 1)
                cpu_req(1'($urandom), 26'($urandom), 2'($urandom), 16'($urandom));
            if (bus.aud_req) begin
                if (bus.aud_ack) begin
                    bus.aud_req = 0; agap = $urandom_range(0, 3);
                end
            end else if (agap > 0) agap--;
            else if ($urandom_range(0, 1) == 1)
                aud_rq(26'($urandom));
            if (g_act && g_cnt == 0) rlat = $urandom_range(0, 3);
            drive_bridge(rlat, $urandom_range(0, 4) == 0);
        end
        bus.init_bus_enable = 0;
        bus.aud_req = 0;
        run(8, 0, 0, 0);

        // asynchronous reset in the middle of a CPU grant
        cpu_req(1'b1, 26'h0003333, 2'b11, 16'h0);
        run(1, -1, 1, 0);
        chk("pre_rst_rd", 32'(bus.ar_read), 32'd1);
        #2 rst = 1;
        #1;
        chk("rst_mid_rd", 32'(bus.ar_read), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_ack", 32'(bus.init_acknowledge), 32'd0);
        chk("rst_mid_terr", 32'(bus.timeout_err), 32'd0);
        chk("rst_mid_addr", 32'(bus.ar_addr), 32'd0);
        bus.init_bus_enable = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        clr_stats();
        cpu_req(1'b0, 26'h0000055, 2'b01, 16'h1234);
        aud_rq(26'h0300000);
        run(12, 0, 0, 0);
        chk("tie_n", 32'(ack_who.size()), 32'd2);
        if (ack_who.size() > 0) chk("tie_first", 32'(ack_who[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
